gmii_rx_deframer: RTL and testbench
===================================

Name: gmii_rx_deframer

Overview:
- Receive-side counterpart of the GMII frame source used in our network benches.
- Accepts a raw GMII byte stream (preamble, SFD, payload, FCS), strips preamble/SFD/FCS, and checks the Ethernet CRC32.
- Emits payload as a framed byte stream with start/end markers and an end-of-frame status.
- Synthesizable; sits between the GMII PHY pins (or a bench source) and the switch ingress logic.

Parameters:
pMIN_LEN, 64, minimum legal frame length in bytes, including FCS; shorter frames are runts
pMAX_LEN, 1518, maximum legal frame length in bytes, including FCS; longer frames are oversize
pMAX_PREAMBLE, 7, maximum count of 0x55 bytes accepted before SFD

Ports:
iclk  in  1  clock, one GMII byte per cycle
irst_n  in  1  asynchronous active-low reset
ival  in  1  GMII RX_DV
ier  in  1  GMII RX_ER
idata  in  8  GMII RXD
oval  out  1  payload byte valid
odata  out  8  payload byte
osop  out  1  first payload byte of frame (qualified by oval)
oeop  out  1  last payload byte of frame (qualified by oval)
oerr  out  1  frame bad; valid only with oeop
oerr_type  out  2  0 none, 1 CRC, 2 length, 3 RX_ER; valid only with oeop
opkt_cnt  out  8  frames delivered with oeop, wrapping

Behaviour:
- Reset is fixed: one clock, asynchronous active-low irst_n. All outputs reset to 0, the FSM to stIDLE, and the CRC register to all ones.
- FSM states: stIDLE, stPREAMBLE, stDATA, stDROP.
- stIDLE: ival=1 with idata=0x55 -> stPREAMBLE with pre_cnt=1. Any other byte with ival=1 -> stDROP.
- stPREAMBLE, on 0x55: increment pre_cnt; if pre_cnt exceeds pMAX_PREAMBLE -> stDROP.
- stPREAMBLE, on 0xD5: -> stDATA, CRC register set to 0xFFFFFFFF, length counter cleared.
- stPREAMBLE, on any other byte: -> stDROP.
- stPREAMBLE, ival=0: -> stIDLE. Nothing is emitted.
- stDATA: each valid byte enters a 4-deep shift line. The byte shifted out moves into a pending register and is folded into the CRC with eth_crc32_8d. The previously pending byte is emitted with oval=1; osop=1 on the first emission.
- stDATA length counter: increments per byte and saturates at pMAX_LEN+1. Once it exceeds pMAX_LEN, no further bytes are emitted and the frame is marked length-error.
- ier=1 while in stDATA sets a sticky rx_er flag for the frame.
- Frame end is ival falling while in stDATA.
  - The pending byte is emitted with oeop=1 on the next cycle.
  - The shift line holds the FCS. Expected FCS byte j bit k = ~crc[31-8j-k]; mismatch is a CRC error.
  - oerr_type priority: RX_ER > length > CRC. oerr = (oerr_type != 0).
  - opkt_cnt increments on that cycle. FSM -> stIDLE.
- Short frames: ival falls with 4 or fewer data bytes -> no output at all, opkt_cnt unchanged.
- Runt: frame length (payload + FCS) below pMIN_LEN but with 5 or more bytes -> delivered with length error.
- Total latency from an idata byte to its odata is 5 cycles while streaming.
- stDROP: ignore bytes until ival=0, then -> stIDLE.
- Back-to-back frames: ival low for one cycle is sufficient. The oeop cycle may coincide with the next frame's preamble; no loss.
- Asynchronous reset mid-frame aborts the frame: no oeop is emitted and state is lost.

Optional Feature:
- Macro: GMII_RX_STATS_EN.
- When defined, adds 32-bit output counters ogood_cnt, ocrc_err_cnt, olen_err_cnt, ofrag_cnt.
  - ofrag_cnt counts short frames (4 or fewer data bytes) and stDROP entries.
  - All counters saturate at 0xFFFFFFFF and reset to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package gmii_pkg holds:
  - the state enum;
  - constants PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5, FCS_LEN=4;
  - the oerr_type enum {ERR_NONE, ERR_CRC, ERR_LEN, ERR_RXER};
  - the function eth_crc32_8d, moved from crc.v so the frame source and this block share one CRC.
- One sub-module: gmii_fcs_delay, the 4-deep shift line plus pending register, exposing the emitted byte, the pending byte, and the 32-bit FCS view.

Test Plan:
- 64-byte frame (60 payload + correct FCS), 7x0x55 + 0xD5 -> 60 oval bytes, osop on byte 0, oeop on byte 59, oerr=0, opkt_cnt=1; first odata 5 cycles after the first payload idata.
- Same frame with one payload bit flipped -> 60 bytes delivered, oeop with oerr=1, oerr_type=1.
- 40-byte frame with correct FCS -> 36 bytes out, oerr_type=2. 1600-byte frame -> exactly 1514 bytes emitted, oerr_type=2.
- ier pulsed on payload byte 10 of a bad-CRC 64-byte frame -> oerr_type=3 (priority over CRC).
- Preamble 0x55,0x55,0x12 ... -> no oval for the frame; frame bytes 0x55,0xD5 + 3 bytes -> no oval; opkt_cnt unchanged in both.
- Two valid 64-byte frames separated by 1 idle cycle -> both delivered intact, opkt_cnt=2. Then irst_n low at payload byte 30 of a third frame -> all outputs 0 immediately, no oeop.

Source files
------------

// File: rtl/gmii_rx_deframer_pkg.sv
// Shared GMII definitions: FSM states, framing constants, error codes and the byte-wise Ethernet CRC32.
package gmii_pkg;

    typedef enum logic [1:0] {
        stIDLE,
        stPREAMBLE,
        stDATA,
        stDROP
    } gmii_state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_CRC  = 2'd1,
        ERR_LEN  = 2'd2,
        ERR_RXER = 2'd3
    } gmii_err_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int          FCS_LEN       = 4;
    localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;

    // MSB-first register, data bits consumed LSB first; FCS byte j bit k is ~crc[31-8j-k].
    function automatic logic [31:0] eth_crc32_8d(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int k = 0; k < 8; k++) begin
            fb = c[31] ^ data[k];
            c  = {c[30:0], 1'b0};
            if (fb) begin
                c = c ^ CRC32_POLY;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/gmii_fcs_delay.sv
// Holds the last FCS_LEN frame bytes back from the output so the FCS never reaches the payload
// stream, plus the pending byte that is next in line for emission.
module gmii_fcs_delay
    import gmii_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_shift,
    input  logic                 i_load,
    input  logic [7:0]           i_byte,
    output logic [7:0]           o_shift_out,
    output logic [7:0]           o_pend,
    output logic [8*FCS_LEN-1:0] o_fcs
);

    logic [7:0] r_line [FCS_LEN];
    logic [7:0] r_pend;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FCS_LEN; i++) begin
                r_line[i] <= '0;
            end
            r_pend <= '0;
        end else begin
            if (i_shift) begin
                r_line[0] <= i_byte;
                for (int i = 1; i < FCS_LEN; i++) begin
                    r_line[i] <= r_line[i-1];
                end
            end
            if (i_load) begin
                r_pend <= r_line[FCS_LEN-1];
            end
        end
    end

    assign o_shift_out = r_line[FCS_LEN-1];
    assign o_pend      = r_pend;

    // Oldest byte (first FCS byte on the wire) lands in the low byte lane.
    always_comb begin
        o_fcs = '0;
        for (int j = 0; j < FCS_LEN; j++) begin
            o_fcs[8*j +: 8] = r_line[FCS_LEN-1-j];
        end
    end

endmodule

// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD/FCS, checks CRC32, flags length and RX_ER errors.
// Defining GMII_RX_STATS_EN adds saturating good/CRC/length/fragment counters.
module gmii_rx_deframer
    import gmii_pkg::*;
#(
    parameter int pMIN_LEN      = 64,
    parameter int pMAX_LEN      = 1518,
    parameter int pMAX_PREAMBLE = 7
) (
    input  logic        iclk,
    input  logic        irst_n,
    input  logic        ival,
    input  logic        ier,
    input  logic [7:0]  idata,
    output logic        oval,
    output logic [7:0]  odata,
    output logic        osop,
    output logic        oeop,
    output logic        oerr,
    output logic [1:0]  oerr_type,
    output logic [7:0]  opkt_cnt
`ifdef GMII_RX_STATS_EN
    ,
    output logic [31:0] ogood_cnt,
    output logic [31:0] ocrc_err_cnt,
    output logic [31:0] olen_err_cnt,
    output logic [31:0] ofrag_cnt
`endif
);

    localparam int LEN_W = $clog2(pMAX_LEN + 2);
    localparam int PRE_W = $clog2(pMAX_PREAMBLE + 2);
    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(pMAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(pMAX_LEN);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(pMIN_LEN);
    localparam logic [LEN_W-1:0] LEN_FCS = LEN_W'(FCS_LEN);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(pMAX_PREAMBLE);

    gmii_state_t          r_state;
    gmii_state_t          w_state_nxt;
    logic [PRE_W-1:0]     r_pre_cnt;
    logic [LEN_W-1:0]     r_len;
    logic [31:0]          r_crc;
    logic                 r_rx_er;
    logic                 r_sop_pend;

    logic                 r_oval;
    logic [7:0]           r_odata;
    logic                 r_osop;
    logic                 r_oeop;
    logic                 r_oerr;
    logic [1:0]           r_oerr_type;
    logic [7:0]           r_opkt_cnt;

    logic                 w_in_data;
    logic                 w_byte;
    logic                 w_end;
    logic                 w_len_ok;
    logic                 w_load;
    logic                 w_emit;
    logic                 w_deliver;
    logic                 w_sfd;
    logic                 w_pre_first;
    logic                 w_pre_inc;
    logic                 w_crc_bad;
    logic                 w_len_bad;
    logic                 w_rxer;
    gmii_err_t            w_err_type;
    logic [7:0]           w_shift_out;
    logic [7:0]           w_pend;
    logic [8*FCS_LEN-1:0] w_fcs;
    logic [31:0]          w_fcs_exp;

    gmii_fcs_delay u_fcs_delay (
        .i_clk       (iclk),
        .i_rst_n     (irst_n),
        .i_shift     (w_byte),
        .i_load      (w_load),
        .i_byte      (idata),
        .o_shift_out (w_shift_out),
        .o_pend      (w_pend),
        .o_fcs       (w_fcs)
    );

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_state <= stIDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            stIDLE: begin
                if (ival) begin
                    w_state_nxt = (idata == PREAMBLE_BYTE) ? stPREAMBLE : stDROP;
                end
            end
            stPREAMBLE: begin
                if (!ival) begin
                    w_state_nxt = stIDLE;
                end else if (idata == SFD_BYTE) begin
                    w_state_nxt = stDATA;
                end else if ((idata != PREAMBLE_BYTE) || (r_pre_cnt >= PRE_MAX)) begin
                    w_state_nxt = stDROP;
                end
            end
            stDATA, stDROP: begin
                if (!ival) begin
                    w_state_nxt = stIDLE;
                end
            end
            default: w_state_nxt = stIDLE;
        endcase
    end

    assign w_in_data   = (r_state == stDATA);
    assign w_byte      = w_in_data && ival;
    assign w_end       = w_in_data && !ival;
    assign w_sfd       = (r_state == stPREAMBLE) && (w_state_nxt == stDATA);
    assign w_pre_first = (r_state == stIDLE) && ival && (idata == PREAMBLE_BYTE);
    assign w_pre_inc   = (r_state == stPREAMBLE) && ival && (idata == PREAMBLE_BYTE) && (r_pre_cnt < PRE_MAX);

    // Once the frame would exceed pMAX_LEN the pending byte freezes, so the eop byte is the last legal one.
    assign w_len_ok  = (r_len < LEN_MAX);
    assign w_load    = w_byte && w_len_ok && (r_len >= LEN_FCS);
    assign w_emit    = w_load && (r_len > LEN_FCS);
    assign w_deliver = w_end && (r_len > LEN_FCS);

    always_comb begin
        w_fcs_exp = '0;
        for (int i = 0; i < 32; i++) begin
            w_fcs_exp[i] = ~r_crc[31-i];
        end
    end

    assign w_crc_bad = (w_fcs != w_fcs_exp);
    assign w_len_bad = (r_len < LEN_MIN) || (r_len > LEN_MAX);
    assign w_rxer    = r_rx_er || ier;

    always_comb begin
        w_err_type = ERR_NONE;
        if (w_rxer) begin
            w_err_type = ERR_RXER;
        end else if (w_len_bad) begin
            w_err_type = ERR_LEN;
        end else if (w_crc_bad) begin
            w_err_type = ERR_CRC;
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_pre_cnt  <= '0;
            r_len      <= '0;
            r_crc      <= '1;
            r_rx_er    <= 1'b0;
            r_sop_pend <= 1'b0;
        end else begin
            if (w_pre_first) begin
                r_pre_cnt <= PRE_W'(1);
            end else if (w_pre_inc) begin
                r_pre_cnt <= r_pre_cnt + 1'b1;
            end
            if (w_sfd) begin
                r_crc      <= '1;
                r_len      <= '0;
                r_rx_er    <= 1'b0;
                r_sop_pend <= 1'b1;
            end else begin
                if (w_load) begin
                    r_crc <= eth_crc32_8d(r_crc, w_shift_out);
                end
                if (w_byte && (r_len != LEN_SAT)) begin
                    r_len <= r_len + 1'b1;
                end
                if (w_in_data && ier) begin
                    r_rx_er <= 1'b1;
                end
                if (w_emit || w_deliver) begin
                    r_sop_pend <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_oval      <= 1'b0;
            r_odata     <= '0;
            r_osop      <= 1'b0;
            r_oeop      <= 1'b0;
            r_oerr      <= 1'b0;
            r_oerr_type <= '0;
            r_opkt_cnt  <= '0;
        end else begin
            r_oval      <= 1'b0;
            r_odata     <= '0;
            r_osop      <= 1'b0;
            r_oeop      <= 1'b0;
            r_oerr      <= 1'b0;
            r_oerr_type <= '0;
            if (w_emit || w_deliver) begin
                r_oval  <= 1'b1;
                r_odata <= w_pend;
                r_osop  <= r_sop_pend;
            end
            if (w_deliver) begin
                r_oeop      <= 1'b1;
                r_oerr      <= (w_err_type != ERR_NONE);
                r_oerr_type <= w_err_type;
                r_opkt_cnt  <= r_opkt_cnt + 8'd1;
            end
        end
    end

    assign oval      = r_oval;
    assign odata     = r_odata;
    assign osop      = r_osop;
    assign oeop      = r_oeop;
    assign oerr      = r_oerr;
    assign oerr_type = r_oerr_type;
    assign opkt_cnt  = r_opkt_cnt;

`ifdef GMII_RX_STATS_EN
    logic [31:0] r_good_cnt;
    logic [31:0] r_crc_err_cnt;
    logic [31:0] r_len_err_cnt;
    logic [31:0] r_frag_cnt;
    logic        w_short;
    logic        w_drop_entry;

    assign w_short      = w_end && (r_len <= LEN_FCS);
    assign w_drop_entry = (w_state_nxt == stDROP) && (r_state != stDROP);

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_good_cnt    <= '0;
            r_crc_err_cnt <= '0;
            r_len_err_cnt <= '0;
            r_frag_cnt    <= '0;
        end else begin
            if (w_deliver && (w_err_type == ERR_NONE) && (r_good_cnt != '1)) begin
                r_good_cnt <= r_good_cnt + 32'd1;
            end
            if (w_deliver && (w_err_type == ERR_CRC) && (r_crc_err_cnt != '1)) begin
                r_crc_err_cnt <= r_crc_err_cnt + 32'd1;
            end
            if (w_deliver && (w_err_type == ERR_LEN) && (r_len_err_cnt != '1)) begin
                r_len_err_cnt <= r_len_err_cnt + 32'd1;
            end
            if ((w_short || w_drop_entry) && (r_frag_cnt != '1)) begin
                r_frag_cnt <= r_frag_cnt + 32'd1;
            end
        end
    end

    assign ogood_cnt    = r_good_cnt;
    assign ocrc_err_cnt = r_crc_err_cnt;
    assign olen_err_cnt = r_len_err_cnt;
    assign ofrag_cnt    = r_frag_cnt;
`endif

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Directed bench for gmii_rx_deframer: builds GMII streams with a reference CRC32 and checks
// the deframed payload, markers, error codes, packet counter and latency.
module tb_gmii_rx_deframer;

    logic       iclk = 1'b0;
    logic       irst_n;
    logic       ival;
    logic       ier;
    logic [7:0] idata;
    logic       oval;
    logic [7:0] odata;
    logic       osop;
    logic       oeop;
    logic       oerr;
    logic [1:0] oerr_type;
    logic [7:0] opkt_cnt;
`ifdef GMII_RX_STATS_EN
    logic [31:0] ogood_cnt, ocrc_err_cnt, olen_err_cnt, ofrag_cnt;
`endif

    gmii_rx_deframer dut (
        .iclk      (iclk),
        .irst_n    (irst_n),
        .ival      (ival),
        .ier       (ier),
        .idata     (idata),
        .oval      (oval),
        .odata     (odata),
        .osop      (osop),
        .oeop      (oeop),
        .oerr      (oerr),
        .oerr_type (oerr_type),
        .opkt_cnt  (opkt_cnt)
`ifdef GMII_RX_STATS_EN
        ,
        .ogood_cnt    (ogood_cnt),
        .ocrc_err_cnt (ocrc_err_cnt),
        .olen_err_cnt (olen_err_cnt),
        .ofrag_cnt    (ofrag_cnt)
`endif
    );

    always #5 iclk = ~iclk;

    typedef struct {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic       err;
        logic [1:0] et;
        int         cyc;
    } cap_t;

    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] pay_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] tx_q[$];
    cap_t       cap_q[$];
    int         pay_start;
    int         er_idx = -1;
    int         first_pay_cyc;

    int         cap_n, sop_n, eop_n, sop_pos, eop_pos, data_bad, first_cap_cyc;
    logic       eop_err;
    logic [1:0] eop_type;
    logic [7:0] last_data;

    always @(posedge iclk) cyc <= cyc + 1;

    always @(posedge iclk) begin
        cap_t c;
        #1;
        if (oval === 1'b1) begin
            c.d = odata; c.sop = osop; c.eop = oeop; c.err = oerr; c.et = oerr_type; c.cyc = cyc;
            cap_q.push_back(c);
        end
    end

    // Reflected (LSB-first) reference CRC over pay_q; returns the FCS value, byte 0 in bits 7:0.
    function automatic logic [31:0] ref_fcs();
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (pay_q[i]) begin
            c = c ^ {24'h0, pay_q[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    task automatic make_payload(input int n, input int seed);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back(8'((i * 13 + seed * 31 + (i >> 3)) & 255));
    endtask

    task automatic build_tx(input int npre, input int flip);
        logic [31:0] f;
        logic [7:0]  b;
        tx_q.delete();
        repeat (npre) tx_q.push_back(8'h55);
        tx_q.push_back(8'hD5);
        pay_start = tx_q.size();
        f = ref_fcs();
        for (int i = 0; i < pay_q.size(); i++) begin
            b = pay_q[i];
            if (i == flip) b = b ^ 8'h04;
            tx_q.push_back(b);
            exp_q.push_back(b);
        end
        for (int j = 0; j < 4; j++) tx_q.push_back(f[8*j +: 8]);
    endtask

    task automatic drive_tx(input int nbytes, input bit tail);
        for (int i = 0; i < nbytes; i++) begin
            @(negedge iclk);
            ival = 1'b1; idata = tx_q[i]; ier = (i == er_idx);
            if (i == pay_start) first_pay_cyc = cyc + 1;
        end
        if (tail) begin
            @(negedge iclk);
            ival = 1'b0; idata = 8'h00; ier = 1'b0;
        end
    endtask

    task automatic drain();
        repeat (10) @(negedge iclk);
    endtask

    task automatic start_case();
        cap_q.delete(); exp_q.delete(); er_idx = -1;
    endtask

    task automatic scan_cap();
        cap_n = cap_q.size(); sop_n = 0; eop_n = 0; sop_pos = -1; eop_pos = -1;
        data_bad = 0; eop_err = 1'b0; eop_type = 2'd0; first_cap_cyc = -1; last_data = 8'h00;
        for (int i = 0; i < cap_q.size(); i++) begin
            if (i == 0) first_cap_cyc = cap_q[i].cyc;
            if (cap_q[i].sop) begin sop_n++; if (sop_pos < 0) sop_pos = i; end
            if (cap_q[i].eop) begin eop_n++; eop_pos = i; eop_err = cap_q[i].err; eop_type = cap_q[i].et; end
            if (i < exp_q.size() && cap_q[i].d !== exp_q[i]) data_bad++;
            last_data = cap_q[i].d;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge iclk);
        n_total++; if (oval !== 1'b0) $display("FAIL reset_oval: got %b want 0", oval); else n_pass++;
        n_total++; if (osop !== 1'b0 || oeop !== 1'b0) $display("FAIL reset_sop_eop: got %b%b want 00", osop, oeop); else n_pass++;
        n_total++; if (oerr !== 1'b0 || oerr_type !== 2'd0) $display("FAIL reset_err: got %b/%0d want 0/0", oerr, oerr_type); else n_pass++;
        n_total++; if (opkt_cnt !== 8'd0) $display("FAIL reset_pkt_cnt: got %0d want 0", opkt_cnt); else n_pass++;
        n_total++; if (odata !== 8'h00) $display("FAIL reset_odata: got %h want 00", odata); else n_pass++;
        irst_n = 1'b1;
        repeat (2) @(negedge iclk);
    endtask

    task automatic test_good_frame();
        start_case();
        make_payload(60, 1); build_tx(7, -1);
        drive_tx(tx_q.size(), 1'b1); drain(); scan_cap();
        n_total++; if (cap_n != 60) $display("FAIL good_count: got %0d want 60", cap_n); else n_pass++;
        n_total++; if (data_bad != 0) $display("FAIL good_data: got %0d bad bytes want 0", data_bad); else n_pass++;
        n_total++; if (sop_n != 1 || sop_pos != 0) $display("FAIL good_sop: got n=%0d pos=%0d want n=1 pos=0", sop_n, sop_pos); else n_pass++;
        n_total++; if (eop_n != 1 || eop_pos != 59) $display("FAIL good_eop: got n=%0d pos=%0d want n=1 pos=59", eop_n, eop_pos); else n_pass++;
        n_total++; if (eop_err !== 1'b0 || eop_type !== 2'd0) $display("FAIL good_err: got %b/%0d want 0/0", eop_err, eop_type); else n_pass++;
        n_total++; if (opkt_cnt !== 8'd1) $display("FAIL good_pkt_cnt: got %0d want 1", opkt_cnt); else n_pass++;
        n_total++; if (first_cap_cyc - first_pay_cyc != 5) $display("FAIL good_latency: got %0d want 5", first_cap_cyc - first_pay_cyc); else n_pass++;
    endtask

    task automatic test_crc_error();
        start_case();
        make_payload(60, 2); build_tx(7, 17);
        drive_tx(tx_q.size(), 1'b1); drain(); scan_cap();
        n_total++; if (cap_n != 60 || data_bad != 0) $display("FAIL crc_count: got %0d bytes (%0d bad) want 60 (0 bad)", cap_n, data_bad); else n_pass++;
        n_total++; if (eop_n != 1 || eop_err !== 1'b1 || eop_type !== 2'd1) $display("FAIL crc_type: got eop=%0d err=%b type=%0d want 1/1/1", eop_n, eop_err, eop_type); else n_pass++;
        n_total++; if (opkt_cnt !== 8'd2) $display("FAIL crc_pkt_cnt: got %0d want 2", opkt_cnt); else n_pass++;
    endtask

    task automatic test_runt();
        start_case();
        make_payload(36, 3); build_tx(7, -1);
        drive_tx(tx_q.size(), 1'b1); drain(); scan_cap();
        n_total++; if (cap_n != 36 || data_bad != 0) $display("FAIL runt_count: got %0d bytes (%0d bad) want 36 (0 bad)", cap_n, data_bad); else n_pass++;
        n_total++; if (eop_n != 1 || eop_pos != 35 || eop_err !== 1'b1 || eop_type !== 2'd2) $display("FAIL runt_type: got eop=%0d pos=%0d err=%b type=%0d want 1/35/1/2", eop_n, eop_pos, eop_err, eop_type); else n_pass++;
    endtask

    task automatic test_oversize();
        logic [7:0] pkt0;
        start_case();
        pkt0 = opkt_cnt;
        make_payload(1596, 4); build_tx(7, -1);
        drive_tx(tx_q.size(), 1'b1); drain(); scan_cap();
        n_total++; if (cap_n != 1514) $display("FAIL over_count: got %0d want 1514", cap_n); else n_pass++;
        n_total++; if (data_bad != 0 || last_data !== pay_q[1513]) $display("FAIL over_data: got %0d bad, last %h want 0 bad, last %h", data_bad, last_data, pay_q[1513]); else n_pass++;
        n_total++; if (eop_n != 1 || eop_pos != 1513 || eop_type !== 2'd2) $display("FAIL over_type: got eop=%0d pos=%0d type=%0d want 1/1513/2", eop_n, eop_pos, eop_type); else n_pass++;
        n_total++; if (opkt_cnt !== pkt0 + 8'd1) $display("FAIL over_pkt_cnt: got %0d want %0d", opkt_cnt, pkt0 + 8'd1); else n_pass++;
    endtask

    task automatic test_rxer();
        start_case();
        make_payload(60, 5); build_tx(7, 3);
        er_idx = pay_start + 10;
        drive_tx(tx_q.size(), 1'b1); drain(); scan_cap();
        er_idx = -1;
        n_total++; if (cap_n != 60) $display("FAIL rxer_count: got %0d want 60", cap_n); else n_pass++;
        n_total++; if (eop_n != 1 || eop_err !== 1'b1 || eop_type !== 2'd3) $display("FAIL rxer_type: got eop=%0d err=%b type=%0d want 1/1/3", eop_n, eop_err, eop_type); else n_pass++;
    endtask

    task automatic test_bad_preamble();
        logic [7:0] pkt0;
        start_case();
        pkt0 = opkt_cnt;
        tx_q.delete();
        tx_q.push_back(8'h55); tx_q.push_back(8'h55); tx_q.push_back(8'h12);
        for (int i = 0; i < 70; i++) tx_q.push_back(8'(i + 8'hD5));
        pay_start = -1;
        drive_tx(tx_q.size(), 1'b1); drain();
        n_total++; if (cap_q.size() != 0 || opkt_cnt !== pkt0) $display("FAIL badpre_drop: got %0d bytes pkt=%0d want 0 bytes pkt=%0d", cap_q.size(), opkt_cnt, pkt0); else n_pass++;
        tx_q.delete();
        tx_q.push_back(8'h55); tx_q.push_back(8'hD5);
        tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33);
        drive_tx(tx_q.size(), 1'b1); drain();
        n_total++; if (cap_q.size() != 0 || opkt_cnt !== pkt0) $display("FAIL short_drop: got %0d bytes pkt=%0d want 0 bytes pkt=%0d", cap_q.size(), opkt_cnt, pkt0); else n_pass++;
        make_payload(60, 6); build_tx(8, -1);
        drive_tx(tx_q.size(), 1'b1); drain();
        n_total++; if (cap_q.size() != 0 || opkt_cnt !== pkt0) $display("FAIL longpre_drop: got %0d bytes pkt=%0d want 0 bytes pkt=%0d", cap_q.size(), opkt_cnt, pkt0); else n_pass++;
        exp_q.delete();
        make_payload(60, 7); build_tx(1, -1);
        drive_tx(tx_q.size(), 1'b1); drain(); scan_cap();
        n_total++; if (cap_n != 60 || data_bad != 0 || eop_type !== 2'd0) $display("FAIL minpre_frame: got %0d bytes (%0d bad) type=%0d want 60 (0 bad) type=0", cap_n, data_bad, eop_type); else n_pass++;
    endtask

    task automatic test_back_to_back();
        @(negedge iclk); irst_n = 1'b0;
        repeat (2) @(negedge iclk); irst_n = 1'b1;
        @(negedge iclk);
        start_case();
        make_payload(60, 8); build_tx(7, -1);
        drive_tx(tx_q.size(), 1'b1);
        make_payload(60, 9); build_tx(7, -1);
        drive_tx(tx_q.size(), 1'b1);
        drain(); scan_cap();
        n_total++; if (cap_n != 120 || data_bad != 0) $display("FAIL b2b_data: got %0d bytes (%0d bad) want 120 (0 bad)", cap_n, data_bad); else n_pass++;
        n_total++; if (sop_n != 2 || eop_n != 2 || eop_pos != 119) $display("FAIL b2b_markers: got sop=%0d eop=%0d pos=%0d want 2/2/119", sop_n, eop_n, eop_pos); else n_pass++;
        n_total++; if (cap_n == 120 && (cap_q[59].eop !== 1'b1 || cap_q[60].sop !== 1'b1 || cap_q[59].et !== 2'd0 || eop_type !== 2'd0))
            $display("FAIL b2b_bound: got eop59=%b sop60=%b et=%0d/%0d want 1/1/0/0", cap_q[59].eop, cap_q[60].sop, cap_q[59].et, eop_type);
        else if (cap_n != 120) $display("FAIL b2b_bound: got %0d bytes want 120", cap_n);
        else n_pass++;
        n_total++; if (opkt_cnt !== 8'd2) $display("FAIL b2b_pkt_cnt: got %0d want 2", opkt_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic was_streaming;
        start_case();
        make_payload(60, 10); build_tx(7, -1);
        drive_tx(pay_start + 31, 1'b0);
        @(negedge iclk);
        was_streaming = oval;
        irst_n = 1'b0; ival = 1'b0; idata = 8'h00;
        #1;
        n_total++; if (was_streaming !== 1'b1) $display("FAIL rst_pre_stream: got oval=%b want 1", was_streaming); else n_pass++;
        n_total++; if (oval !== 1'b0 || odata !== 8'h00 || osop !== 1'b0 || oeop !== 1'b0)
            $display("FAIL rst_outputs: got val=%b data=%h sop=%b eop=%b want 0/00/0/0", oval, odata, osop, oeop); else n_pass++;
        n_total++; if (oerr !== 1'b0 || oerr_type !== 2'd0 || opkt_cnt !== 8'd0)
            $display("FAIL rst_status: got err=%b type=%0d pkt=%0d want 0/0/0", oerr, oerr_type, opkt_cnt); else n_pass++;
        cap_q.delete();
        repeat (2) @(negedge iclk); irst_n = 1'b1;
        drain();
        n_total++; if (cap_q.size() != 0 || opkt_cnt !== 8'd0) $display("FAIL rst_no_eop: got %0d bytes pkt=%0d want 0/0", cap_q.size(), opkt_cnt); else n_pass++;
    endtask

    initial begin
        irst_n = 1'b0; ival = 1'b0; ier = 1'b0; idata = 8'h00;
        test_reset();
        test_good_frame();
        test_crc_error();
        test_runt();
        test_oversize();
        test_rxer();
        test_bad_preamble();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
